mips_bus_memory: RTL and testbench

- Avalon-MM slave memory model that sits directly downstream of the CPU bus master and serves its instruction fetches and data loads/stores.
- Has two word-addressed windows:
  - instruction window at the reset vector;
  - data window in low memory.
- Inserts configurable fixed or pseudo-random wait states, so the master's waitrequest handling can be exercised.
- Used as the standard memory in CPU testbenches.

---
 rtl/mips_bus_pkg.sv | 23 ++
 rtl/mips_bus_memory_if.sv | 24 ++
 rtl/mips_bus_lfsr.sv | 19 +
 rtl/mips_bus_memory.sv | 145 ++++++++++++++
 tb/tb_mips_bus_memory.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the Avalon-MM CPU memory model.
package mips_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned LFSR_W = 8;

  localparam logic [ADDR_W-1:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [LFSR_W-1:0] LFSR_SEED    = 8'h01;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } bus_state_t;

  // Fibonacci step for x^8 + x^6 + x^5 + x^4 + 1
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/mips_bus_memory_if.sv
// Avalon-MM command/response bundle between the CPU master and the memory model.
interface mips_bus_memory_if;
  import mips_bus_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              bus_error;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, bus_error
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, bus_error
  );

endinterface

// File: rtl/mips_bus_lfsr.sv
// 8-bit Fibonacci LFSR that steps only when told to; drives random wait states.
module mips_bus_lfsr
  import mips_bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= LFSR_SEED;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/mips_bus_memory.sv
// Avalon-MM slave memory with instruction and data windows and programmable
// wait-state insertion, used as the standard memory behind the CPU bus master.
module mips_bus_memory
  import mips_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] INSTR_BASE      = RESET_VECTOR,
  parameter int unsigned       INSTR_WORDS     = 1024,
  parameter logic [ADDR_W-1:0] DATA_BASE       = 32'h0000_1000,
  parameter int unsigned       DATA_WORDS      = 1024,
  parameter string             INSTR_INIT_FILE = "",
  parameter string             DATA_INIT_FILE  = "",
  parameter int unsigned       WAIT_CYCLES     = 0,
  parameter bit                RANDOM_WAIT     = 1'b0
) (
  input logic              clk,
  input logic              rst,
  mips_bus_memory_if.slave bus
);

  localparam int unsigned IW = $clog2(INSTR_WORDS);
  localparam int unsigned DW = $clog2(DATA_WORDS);
  localparam int unsigned WA = ADDR_W - 2;

  logic [DATA_W-1:0] mem_i [INSTR_WORDS];
  logic [DATA_W-1:0] mem_d [DATA_WORDS];

  bus_state_t        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [WAIT_W-1:0] load_c;
  logic              stall_c;
  logic              accept_c;
  logic              req_c;
  logic [LFSR_W-1:0] lfsr_value;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  // Window decode on word addresses; the low address bits never select anything
  logic [WA-1:0] waddr_c, woff_i_c, woff_d_c;
  logic          hit_i_c, hit_d_c, hit_c;
  logic [IW-1:0] idx_i_c;
  logic [DW-1:0] idx_d_c;
  logic          addr_unused;

  assign req_c    = bus.read | bus.write;
  assign waddr_c  = bus.address[ADDR_W-1:2];
  assign woff_i_c = waddr_c - INSTR_BASE[ADDR_W-1:2];
  assign woff_d_c = waddr_c - DATA_BASE[ADDR_W-1:2];
  assign hit_i_c  = (waddr_c >= INSTR_BASE[ADDR_W-1:2]) && (woff_i_c < WA'(INSTR_WORDS));
  assign hit_d_c  = (waddr_c >= DATA_BASE[ADDR_W-1:2])  && (woff_d_c < WA'(DATA_WORDS));
  assign hit_c    = hit_i_c | hit_d_c;
  assign idx_i_c  = woff_i_c[IW-1:0];
  assign idx_d_c  = woff_d_c[DW-1:0];
  assign addr_unused = ^{bus.address[1:0], lfsr_value[LFSR_W-1:2]};

  assign load_c = RANDOM_WAIT ? {2'b00, lfsr_value[1:0]} : WAIT_W'(WAIT_CYCLES);

  mips_bus_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (accept_c),
    .value   (lfsr_value)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall sequencing; reset forces a stall so nothing is accepted while it is held
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    accept_c = 1'b0;
    if (rst) begin
      stall_c = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_c) begin
            if (load_c == '0) begin
              accept_c = 1'b1;
            end else begin
              stall_c = 1'b1;
              cnt_d   = load_c - WAIT_W'(1);
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          if (!req_c) begin
            state_d = IDLE;
          end else if (cnt_q != '0) begin
            stall_c = 1'b1;
            cnt_d   = cnt_q - WAIT_W'(1);
          end else begin
            accept_c = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.waitrequest = stall_c;

  // Lane-masked store; a collision with a read still performs the write
  always_ff @(posedge clk) begin
    if (accept_c && bus.write) begin
      for (int n = 0; n < int'(BE_W); n++) begin
        if (bus.byteenable[n]) begin
          if (hit_i_c) begin
            mem_i[idx_i_c][8*n +: 8] <= bus.writedata[8*n +: 8];
          end else if (hit_d_c) begin
            mem_d[idx_d_c][8*n +: 8] <= bus.writedata[8*n +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept_c) begin
      if (bus.read && !bus.write) begin
        rdata_q <= hit_i_c ? mem_i[idx_i_c] : (hit_d_c ? mem_d[idx_d_c] : '0);
      end
      if (!hit_c || (bus.read && bus.write)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.readdata  = rdata_q;
  assign bus.bus_error = err_q;

endmodule

// File: tb/tb_mips_bus_memory.sv
// Directed and randomized checks of mips_bus_memory against a transaction-level model.
module tb_mips_bus_memory;
  import mips_bus_pkg::*;

  localparam logic [31:0] I_BASE = 32'hBFC0_0000;
  localparam logic [31:0] D_BASE = 32'h0000_1000;
  localparam int          WORDS  = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_bus_memory_if b0();
  mips_bus_memory_if b1();
  mips_bus_memory_if b2();

  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic        rdv  [3];
  logic        wrv  [3];
  logic [3:0]  bev  [3];

  assign b0.address = addr[0]; assign b0.read = rdv[0]; assign b0.write = wrv[0];
  assign b0.writedata = wdat[0]; assign b0.byteenable = bev[0];
  assign b1.address = addr[1]; assign b1.read = rdv[1]; assign b1.write = wrv[1];
  assign b1.writedata = wdat[1]; assign b1.byteenable = bev[1];
  assign b2.address = addr[2]; assign b2.read = rdv[2]; assign b2.write = wrv[2];
  assign b2.writedata = wdat[2]; assign b2.byteenable = bev[2];

  mips_bus_memory #(.WAIT_CYCLES(0))                  dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  mips_bus_memory #(.WAIT_CYCLES(3))                  dut3 (.clk(clk), .rst(rst), .bus(b1.slave));
  mips_bus_memory #(.WAIT_CYCLES(9), .RANDOM_WAIT(1)) dutr (.clk(clk), .rst(rst), .bus(b2.slave));

  int checks = 0;
  int errors = 0;

  function automatic logic get_wr(input int i);
    case (i) 0: return b0.waitrequest; 1: return b1.waitrequest; default: return b2.waitrequest; endcase
  endfunction
  function automatic logic [31:0] get_rd(input int i);
    case (i) 0: return b0.readdata; 1: return b1.readdata; default: return b2.readdata; endcase
  endfunction
  function automatic logic get_err(input int i);
    case (i) 0: return b0.bus_error; 1: return b1.bus_error; default: return b2.bus_error; endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a sparse map of word addresses, windows as numeric ranges
  logic [31:0] mdl_mem [longint];
  logic [31:0] exp_rd  = 32'h0;
  logic        exp_err = 1'b0;

  function automatic void mdl_apply(input logic rd, input logic wr, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [3:0] be);
    longint ua   = longint'(a);
    longint word = ua / 4;
    bit hit = (ua >= longint'(I_BASE) && ua < longint'(I_BASE) + 4 * WORDS) ||
              (ua >= longint'(D_BASE) && ua < longint'(D_BASE) + 4 * WORDS);
    if (wr) begin
      if (hit) begin
        logic [31:0] w;
        w = mdl_mem.exists(word) ? mdl_mem[word] : 32'h0;
        for (int n = 0; n < 4; n++) if (be[n]) w[8*n +: 8] = wd[8*n +: 8];
        mdl_mem[word] = w;
      end else begin
        exp_err = 1'b1;
      end
    end
    if (rd && wr) begin
      exp_err = 1'b1;
    end else if (rd) begin
      if (hit) exp_rd = mdl_mem[word];
      else begin
        exp_rd  = 32'h0;
        exp_err = 1'b1;
      end
    end
  endfunction

  function automatic logic [31:0] mdl_word(input logic [31:0] a);
    return mdl_mem[longint'(a) / 4];
  endfunction

  // One bus transaction; returns stall cycles and readdata seen just before acceptance
  task automatic access(input int i, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output int stalls, output logic [31:0] rd_before);
    @(negedge clk);
    addr[i] = a; rdv[i] = rd; wrv[i] = wr; wdat[i] = wd; bev[i] = be;
    stalls = 0;
    #1;
    while (get_wr(i) !== 1'b0 && stalls < 40) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    rd_before = get_rd(i);
    @(negedge clk);
    rdv[i] = 1'b0; wrv[i] = 1'b0;
    #1;
  endtask

  task automatic op0(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be);
    int st;
    logic [31:0] rb;
    access(0, rd, wr, a, wd, be, st, rb);
    mdl_apply(rd, wr, a, wd, be);
    check({tag, ".stall"}, 32'(st), 32'd0);
    check({tag, ".rdata"}, get_rd(0), exp_rd);
    check({tag, ".err"}, 32'(get_err(0)), 32'(exp_err));
  endtask

  initial begin
    int st;
    logic [31:0] rb;
    logic [31:0] a0, a1;
    logic [7:0] lf;

    for (int i = 0; i < 3; i++) begin
      addr[i] = '0; wdat[i] = '0; rdv[i] = 1'b0; wrv[i] = 1'b0; bev[i] = '0;
    end

    // Reset state
    #12;
    for (int i = 0; i < 3; i++) begin
      check("rst.wait", 32'(get_wr(i)), 32'd1);
      check("rst.rdata", get_rd(i), 32'h0);
      check("rst.err", 32'(get_err(i)), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle.wait", 32'(get_wr(0)), 32'd0);

    // Zero-wait: prefill a pool of words, then directed cases
    for (int i = 0; i < 16; i++) op0("fill_d", 1'b0, 1'b1, D_BASE + 32'(4 * i), $urandom, 4'hF);
    for (int i = 0; i < 8; i++)  op0("fill_i", 1'b0, 1'b1, I_BASE + 32'(4 * i), $urandom, 4'hF);
    op0("ivec_w", 1'b0, 1'b1, I_BASE, 32'h2402_0005, 4'hF);
    op0("ivec_r", 1'b1, 1'b0, I_BASE, 32'h0, 4'h0);
    check("ivec.value", get_rd(0), 32'h2402_0005);

    op0("lane_w1", 1'b0, 1'b1, 32'h0000_1004, 32'hAABB_CCDD, 4'b1111);
    op0("lane_w2", 1'b0, 1'b1, 32'h0000_1004, 32'h1122_3344, 4'b0101);
    op0("lane_r", 1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0);
    check("lane.value", get_rd(0), 32'hAA22_CC44);
    op0("be0_w", 1'b0, 1'b1, 32'h0000_1004, 32'hFFFF_FFFF, 4'b0000);
    op0("be0_r", 1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0);

    op0("dlast_w", 1'b0, 1'b1, 32'h0000_1FFC, 32'h600D_0001, 4'hF);
    op0("dlast_r", 1'b1, 1'b0, 32'h0000_1FFF, 32'h0, 4'h0);
    op0("ilast_w", 1'b0, 1'b1, 32'hBFC0_0FFC, 32'h600D_0002, 4'hF);
    op0("ilast_r", 1'b1, 1'b0, 32'hBFC0_0FFC, 32'h0, 4'h0);
    check("inrange.noerr", 32'(get_err(0)), 32'd0);

    // Back-to-back zero-wait reads with no idle cycle between them
    a0 = D_BASE + 32'd8; a1 = I_BASE + 32'd4;
    @(negedge clk);
    addr[0] = a0; rdv[0] = 1'b1; #1;
    check("b2b.wait0", 32'(get_wr(0)), 32'd0);
    @(negedge clk);
    addr[0] = a1; #1;
    check("b2b.first", get_rd(0), mdl_word(a0));
    check("b2b.wait1", 32'(get_wr(0)), 32'd0);
    @(negedge clk);
    rdv[0] = 1'b0; #1;
    check("b2b.second", get_rd(0), mdl_word(a1));
    mdl_apply(1'b1, 1'b0, a0, 32'h0, 4'h0);
    mdl_apply(1'b1, 1'b0, a1, 32'h0, 4'h0);

    // Error cases
    op0("oow_w", 1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF);
    check("oow_w.err", 32'(get_err(0)), 32'd1);
    op0("both", 1'b1, 1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 4'hF);
    op0("both_rb", 1'b1, 1'b0, 32'h0000_1008, 32'h0, 4'h0);
    check("both.mem", get_rd(0), 32'hDEAD_BEEF);
    op0("oow_r0", 1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'h0);
    op0("oow_rib", 1'b1, 1'b0, 32'hBFBF_FFFC, 32'h0, 4'h0);
    op0("oow_r2k", 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0);

    // Randomized traffic over the prefilled pool plus out-of-window addresses
    for (int k = 0; k < 40; k++) begin
      int kind;
      logic [31:0] a;
      logic rd, wr;
      kind = int'($urandom_range(0, 9));
      if ($urandom_range(0, 1) == 1) a = D_BASE + 32'(4 * $urandom_range(0, 15));
      else                           a = I_BASE + 32'(4 * $urandom_range(0, 7));
      a[1:0] = 2'($urandom);
      if (kind == 9) begin
        case ($urandom_range(0, 2))
          0:       a = D_BASE + 32'(4 * WORDS);
          1:       a = I_BASE - 32'd4;
          default: a = $urandom & 32'h0000_0FFC;
        endcase
      end
      rd = (kind <= 3) || (kind == 8) || (kind == 9 && $urandom_range(0, 1) == 1);
      wr = (kind >= 4 && kind <= 8) || (kind == 9 && !rd);
      op0("rand", rd, wr, a, $urandom, 4'($urandom));
    end

    // Fixed three wait states, including a dropped request
    access(1, 1'b0, 1'b1, D_BASE, 32'hAABB_0011, 4'hF, st, rb);
    check("w3.wstall", 32'(st), 32'd3);
    access(1, 1'b1, 1'b0, D_BASE, 32'h0, 4'h0, st, rb);
    check("w3.rstall", 32'(st), 32'd3);
    check("w3.before", rb, 32'h0);
    check("w3.rdata", get_rd(1), 32'hAABB_0011);
    @(negedge clk);
    addr[1] = D_BASE; wdat[1] = 32'h0BAD_F00D; bev[1] = 4'hF; wrv[1] = 1'b1; #1;
    check("drop.stall", 32'(get_wr(1)), 32'd1);
    @(negedge clk);
    wrv[1] = 1'b0;
    @(negedge clk); #1;
    check("drop.idle", 32'(get_wr(1)), 32'd0);
    access(1, 1'b1, 1'b0, D_BASE, 32'h0, 4'h0, st, rb);
    check("drop.fresh", 32'(st), 32'd3);
    check("drop.nowrite", get_rd(1), 32'hAABB_0011);
    check("drop.err", 32'(get_err(1)), 32'd0);

    // Random wait states follow the LFSR sequence from its seed
    lf = LFSR_SEED;
    access(2, 1'b0, 1'b1, D_BASE, 32'h5A5A_0001, 4'hF, st, rb);
    check("lfsr.wstall", 32'(st), 32'(lf[1:0]));
    lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
    for (int k = 0; k < 16; k++) begin
      access(2, 1'b1, 1'b0, D_BASE, 32'h0, 4'h0, st, rb);
      check("lfsr.stall", 32'(st), 32'(lf[1:0]));
      check("lfsr.rdata", get_rd(2), 32'h5A5A_0001);
      lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
    end
    for (int g = 0; g < 8 && lf[1:0] == 2'b00; g++) begin
      access(2, 1'b1, 1'b0, D_BASE, 32'h0, 4'h0, st, rb);
      check("lfsr.skip", 32'(st), 32'd0);
      lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
    end

    // Reset in the middle of a stalled write
    @(negedge clk);
    addr[2] = D_BASE; wdat[2] = 32'hFFFF_FFFF; bev[2] = 4'hF; wrv[2] = 1'b1; #1;
    check("midrst.stall", 32'(get_wr(2)), 32'd1);
    @(negedge clk); #1;
    rst = 1'b1; #1;
    check("midrst.wait", 32'(get_wr(2)), 32'd1);
    check("midrst.rdata", get_rd(2), 32'h0);
    check("midrst.rdata0", get_rd(0), 32'h0);
    check("midrst.err0", 32'(get_err(0)), 32'd0);
    wrv[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_rd = 32'h0; exp_err = 1'b0;
    lf = LFSR_SEED;
    access(2, 1'b1, 1'b0, D_BASE, 32'h0, 4'h0, st, rb);
    check("midrst.seed", 32'(st), 32'(lf[1:0]));
    check("midrst.mem", get_rd(2), 32'h5A5A_0001);
    op0("postrst", 1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
